dphy_lane_tx_seq: RTL and testbench

//  D-PHY data-lane TX sequencer: walks one lane through LP-11 -> SoT -> HS burst -> EoT -> LP-11.

---
 rtl/dphy_lane_tx_seq.sv | 147 ++++++++++++++
 tb/tb_dphy_lane_tx_seq.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dphy_lane_tx_seq.sv
// D-PHY data-lane TX sequencer: LP-11 -> SoT (LPX, PREP, ZERO) -> HS burst -> TRAIL -> EXIT -> LP-11.
// Optional build macro DPHY_TX_SOT_SYNC_EN inserts a one-cycle 8'hB8 sync byte between ZERO and DATA.
module dphy_lane_tx_seq #(
  parameter int T_LPX        = 4,
  parameter int T_HS_PREPARE = 3,
  parameter int T_HS_ZERO    = 8,
  parameter int T_HS_TRAIL   = 5,
  parameter int T_HS_EXIT    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hs_req,
  input  logic        hs_valid,
  input  logic [7:0]  hs_data,
  output logic        hs_ready,
  output logic [1:0]  lp_out,
  output logic        hs_en,
  output logic [7:0]  hs_byte,
  output logic        busy,
  output logic        err_underrun,
  output logic        tmr_enable,
  output logic [31:0] tmr_reload,
  input  logic        tmr_pass
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LPX   = 3'd1,
    S_PREP  = 3'd2,
    S_ZERO  = 3'd3,
`ifdef DPHY_TX_SOT_SYNC_EN
    S_SYNC  = 3'd4,
`endif
    S_DATA  = 3'd5,
    S_TRAIL = 3'd6,
    S_EXIT  = 3'd7
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       pass_seen;
  logic [7:0] last_byte;
  logic       timer_arm;
  logic       timer_done;

  function automatic logic is_timed(state_t s);
    return (s == S_LPX) || (s == S_PREP) || (s == S_ZERO) ||
           (s == S_TRAIL) || (s == S_EXIT);
  endfunction

  function automatic logic [31:0] reload_of(state_t s);
    case (s)
      S_LPX:   return 32'(T_LPX - 1);
      S_PREP:  return 32'(T_HS_PREPARE - 1);
      S_ZERO:  return 32'(T_HS_ZERO - 1);
      S_TRAIL: return 32'(T_HS_TRAIL - 1);
      S_EXIT:  return 32'(T_HS_EXIT - 1);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] lp_of(state_t s);
    case (s)
      S_IDLE, S_EXIT: return 2'b11;
      S_LPX:          return 2'b01;
      default:        return 2'b00;
    endcase
  endfunction

  function automatic logic hs_en_of(state_t s);
    return !((s == S_IDLE) || (s == S_LPX) || (s == S_PREP) || (s == S_EXIT));
  endfunction

  // Passes only count while the timer is enabled, so a stale pulse left over from the
  // previous state's timer can never be mistaken for this state's arming pulse.
  assign timer_arm  = tmr_enable & tmr_pass;
  assign timer_done = timer_arm & pass_seen;
  assign hs_ready   = (state == S_DATA) & hs_req;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (hs_req) nxt = S_LPX;
      S_LPX:   if (timer_done) nxt = S_PREP;
      S_PREP:  if (timer_done) nxt = S_ZERO;
`ifdef DPHY_TX_SOT_SYNC_EN
      S_ZERO:  if (timer_done) nxt = S_SYNC;
      S_SYNC:  nxt = S_DATA;
`else
      S_ZERO:  if (timer_done) nxt = S_DATA;
`endif
      S_DATA:  if (!hs_req) nxt = S_TRAIL;
      S_TRAIL: if (timer_done) nxt = S_EXIT;
      S_EXIT:  if (timer_done) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lp_out       <= 2'b11;
      hs_en        <= 1'b0;
      hs_byte      <= 8'h00;
      busy         <= 1'b0;
      err_underrun <= 1'b0;
      tmr_enable   <= 1'b0;
      tmr_reload   <= 32'd0;
      pass_seen    <= 1'b0;
      last_byte    <= 8'h00;
    end else begin
      state        <= nxt;
      err_underrun <= 1'b0;
      if (nxt != state) begin
        // Entry cycle of every state: timer held cleared, outputs reflect the new state.
        pass_seen  <= 1'b0;
        tmr_enable <= 1'b0;
        tmr_reload <= reload_of(nxt);
        lp_out     <= lp_of(nxt);
        hs_en      <= hs_en_of(nxt);
        busy       <= (nxt != S_IDLE);
        case (nxt)
          S_LPX:   last_byte <= 8'h00;
`ifdef DPHY_TX_SOT_SYNC_EN
          S_SYNC:  hs_byte <= 8'hB8;
`endif
          S_TRAIL: hs_byte <= {8{~last_byte[7]}};
          S_ZERO, S_DATA, S_EXIT, S_IDLE: hs_byte <= 8'h00;
          default: ;
        endcase
      end else begin
        if (is_timed(state)) tmr_enable <= 1'b1;
        if (timer_arm) pass_seen <= 1'b1;
        if ((state == S_DATA) && hs_req) begin
          if (hs_valid) begin
            hs_byte   <= hs_data;
            last_byte <= hs_data;
          end else begin
            hs_byte      <= 8'h00;
            err_underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dphy_lane_tx_seq.sv
// Bench for dphy_lane_tx_seq: duration-based lane model plus a down-counter timer model,
// directed SoT/burst/underrun/reset scenarios and randomized bursts.
module tb_dphy_lane_tx_seq;

  localparam int T_LPX = 4, T_PREP = 3, T_ZERO = 8, T_TRAIL = 5, T_EXIT = 6;
`ifdef DPHY_TX_SOT_SYNC_EN
  localparam int D = 26;
`else
  localparam int D = 25;
`endif
  localparam int P_IDLE = 0, P_LPX = 1, P_PREP = 2, P_ZERO = 3, P_SYNC = 4,
                 P_DATA = 5, P_TRAIL = 6, P_EXIT = 7;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hs_req = 1'b0, hs_valid = 1'b0;
  logic [7:0]  hs_data = 8'h00;
  logic        hs_ready, hs_en, busy, err_underrun, tmr_enable, tmr_pass;
  logic [1:0]  lp_out;
  logic [7:0]  hs_byte;
  logic [31:0] tmr_reload;

  int checks = 0, errors = 0;
  int m_ph = P_IDLE, m_idx = 0, bursts = 0, n_acc = 0, n_und = 0;
  logic [7:0] m_last = 8'h00, m_byte = 8'h00;
  logic       m_und = 1'b0;

  logic [31:0] t_cnt;

  dphy_lane_tx_seq #(.T_LPX(T_LPX), .T_HS_PREPARE(T_PREP), .T_HS_ZERO(T_ZERO),
                     .T_HS_TRAIL(T_TRAIL), .T_HS_EXIT(T_EXIT)) dut (
    .clk(clk), .rst(rst), .hs_req(hs_req), .hs_valid(hs_valid), .hs_data(hs_data),
    .hs_ready(hs_ready), .lp_out(lp_out), .hs_en(hs_en), .hs_byte(hs_byte), .busy(busy),
    .err_underrun(err_underrun), .tmr_enable(tmr_enable), .tmr_reload(tmr_reload),
    .tmr_pass(tmr_pass));

  always #5 clk = ~clk;

  // Shared down-counter timer: cleared while disabled, pulses and reloads on reaching zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_cnt <= 32'd0; tmr_pass <= 1'b0;
    end else if (!tmr_enable) begin
      t_cnt <= 32'd0; tmr_pass <= 1'b0;
    end else begin
      tmr_pass <= (t_cnt == 32'd0);
      t_cnt    <= (t_cnt == 32'd0) ? tmr_reload : t_cnt - 32'd1;
    end
  end

  function automatic int t_of(int ph);
    case (ph)
      P_LPX: return T_LPX;   P_PREP: return T_PREP;  P_ZERO: return T_ZERO;
      P_TRAIL: return T_TRAIL; P_EXIT: return T_EXIT; default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    logic exp_hs;
    exp_hs = (m_ph == P_ZERO) || (m_ph == P_SYNC) || (m_ph == P_DATA) || (m_ph == P_TRAIL);
    check("lp_out", 32'(lp_out), (m_ph == P_IDLE || m_ph == P_EXIT) ? 32'd3 : (m_ph == P_LPX) ? 32'd1 : 32'd0);
    check("hs_en", 32'(hs_en), 32'(exp_hs));
    check("busy", 32'(busy), 32'(m_ph != P_IDLE));
    check("tmr_enable", 32'(tmr_enable), 32'(t_of(m_ph) != 0 && m_idx > 0));
    check("hs_ready", 32'(hs_ready), 32'(m_ph == P_DATA && hs_req));
    check("err_underrun", 32'(err_underrun), 32'(m_und));
    if (t_of(m_ph) != 0) check("tmr_reload", tmr_reload, 32'(t_of(m_ph) - 1));
    if (exp_hs) check("hs_byte", 32'(hs_byte), 32'(m_byte));
  endtask

  task automatic go(input int ph);
    m_ph = ph; m_idx = 0;
  endtask

  // Advance the model across the coming clock edge using the inputs now on the pins.
  task automatic step();
    m_und = 1'b0;
    if (m_ph == P_IDLE) begin
      if (hs_req) begin go(P_LPX); m_last = 8'h00; n_acc = 0; n_und = 0; end
    end else if (m_ph == P_SYNC) begin
      go(P_DATA); m_byte = 8'h00;
    end else if (m_ph == P_DATA) begin
      if (!hs_req) begin
        go(P_TRAIL); m_byte = {8{~m_last[7]}}; bursts++;
        $display("burst %0d: %0d bytes accepted, %0d underruns, last %02h", bursts, n_acc, n_und, m_last);
      end else if (hs_valid) begin
        m_byte = hs_data; m_last = hs_data; n_acc++;
      end else begin
        m_byte = 8'h00; m_und = 1'b1; n_und++;
      end
    end else if (m_idx == t_of(m_ph) + 2) begin
      case (m_ph)
        P_LPX:  go(P_PREP);
`ifdef DPHY_TX_SOT_SYNC_EN
        P_ZERO: begin go(P_SYNC); m_byte = 8'hB8; end
`else
        P_ZERO: begin go(P_DATA); m_byte = 8'h00; end
`endif
        P_PREP: begin go(P_ZERO); m_byte = 8'h00; end
        P_TRAIL: go(P_EXIT);
        default: go(P_IDLE);
      endcase
    end else begin
      m_idx++;
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d);
    @(negedge clk);
    hs_req = r; hs_valid = v; hs_data = d;
    #1;
    compare();
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && m_ph != P_IDLE; i++) cyc(1'b0, 1'b0, 8'h00);
    check("idle_timeout", 32'(m_ph == P_IDLE), 32'd1);
  endtask

  initial begin
    logic r, v;
    logic [7:0] d;
    repeat (2) @(negedge clk);
    #1;
    check("rst_lp", 32'(lp_out), 32'd3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hs_en", 32'(hs_en), 32'd0);
    check("rst_reload", tmr_reload, 32'd0);
    check("rst_byte", 32'(hs_byte), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // SoT timing, two-byte burst, trail and exit; hs_req wiggles during SoT are ignored.
    wait_idle();
    for (int c = 0; c <= D + 21; c++) begin
      r = (c == 0) || (c >= D && c <= D + 1) || (c > 1 && c < D && ($urandom_range(1) == 1));
      v = (c == D) || (c == D + 1);
      d = (c == D) ? 8'hA5 : (c == D + 1) ? 8'h3C : 8'($urandom);
      cyc(r, v, d);
      if (c == 1)  begin check("lit_lpx_lp", 32'(lp_out), 32'd1); check("lit_lpx_rl", tmr_reload, 32'd3); end
      if (c == 7)  check("lit_lpx_end", 32'(lp_out), 32'd1);
      if (c == 8)  begin check("lit_prep_en", 32'(hs_en), 32'd0); check("lit_prep_rl", tmr_reload, 32'd2); end
      if (c == 13) check("lit_prep_end", 32'(hs_en), 32'd0);
      if (c == 14) begin check("lit_zero_en", 32'(hs_en), 32'd1); check("lit_zero_rl", tmr_reload, 32'd7); end
`ifdef DPHY_TX_SOT_SYNC_EN
      if (c == 25) check("lit_sync", 32'(hs_byte), 32'hB8);
`endif
      if (c == D + 1)  check("lit_b0", 32'(hs_byte), 32'hA5);
      if (c == D + 2)  check("lit_b1", 32'(hs_byte), 32'h3C);
      if (c == D + 3)  check("lit_trail", 32'(hs_byte), 32'hFF);
      if (c == D + 11) check("lit_exit_lp", 32'(lp_out), 32'd3);
      if (c == D + 19) check("lit_exit_end", 32'(busy), 32'd1);
      if (c == D + 20) check("lit_idle", 32'(busy), 32'd0);
    end

    // Two-cycle underrun inside a burst; last byte has bit 7 set so the trail is 8'h00.
    wait_idle();
    for (int c = 0; c <= D + 6; c++) begin
      r = (c <= D + 3);
      v = (c == D) || (c == D + 3);
      d = (c == D) ? 8'h11 : 8'h9A;
      cyc(r, v, d);
      if (c == D + 1) check("lit_u_b0", 32'(hs_byte), 32'h11);
      if (c == D + 2) begin check("lit_u_z0", 32'(hs_byte), 32'h00); check("lit_u_e0", 32'(err_underrun), 32'd1); end
      if (c == D + 3) begin check("lit_u_z1", 32'(hs_byte), 32'h00); check("lit_u_e1", 32'(err_underrun), 32'd1); end
      if (c == D + 4) begin check("lit_u_b1", 32'(hs_byte), 32'h9A); check("lit_u_e2", 32'(err_underrun), 32'd0); end
      if (c == D + 5) check("lit_u_trail", 32'(hs_byte), 32'h00);
    end

    // One-cycle request: empty burst; hs_req held through EXIT must not shorten it.
    wait_idle();
    for (int c = 0; c <= D + 19; c++) begin
      r = (c == 0) || (c >= D + 9);
      cyc(r, 1'b1, 8'h55);
      if (c == D)      check("lit_e_ready", 32'(hs_ready), 32'd0);
      if (c == D + 1)  check("lit_e_trail", 32'(hs_byte), 32'hFF);
      if (c == D + 17) check("lit_e_exit", 32'(lp_out), 32'd3);
      if (c == D + 18) check("lit_e_idle", 32'(busy), 32'd0);
      if (c == D + 19) check("lit_e_lpx", 32'(lp_out), 32'd1);
    end

    // Asynchronous reset in the middle of DATA.
    wait_idle();
    for (int c = 0; c <= D + 2; c++) cyc(1'b1, 1'b1, 8'($urandom));
    #2 rst = 1'b1;
    hs_req = 1'b0;
    #1;
    check("arst_lp", 32'(lp_out), 32'd3);
    check("arst_hs_en", 32'(hs_en), 32'd0);
    check("arst_tmr_en", 32'(tmr_enable), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(hs_ready), 32'd0);
    m_ph = P_IDLE; m_idx = 0; m_byte = 8'h00; m_und = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      case (m_ph)
        P_IDLE:  r = ($urandom_range(3) == 0);
        P_DATA:  r = ($urandom_range(7) != 0);
        default: r = ($urandom_range(1) == 1);
      endcase
      v = ($urandom_range(4) != 0);
      cyc(r, v, 8'($urandom));
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
